// File: rtl/cpu_mem_bridge.sv
// Memory bridge between the MIPS core and the synchronous inst/data SRAMs.
// Each channel runs its own request/ack FSM; stall holds the core until every pending access acks.

module cpu_mem_bridge_chan #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic                ack,
  output logic [DATA_W-1:0]   rdata,
  output logic                sram_en,
  output logic [DATA_W/8-1:0] sram_wen,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);
  localparam int CW = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              issue;

  // Gated by resetn so nothing reaches the SRAM while the bridge is held in reset.
  assign issue      = (state_q == IDLE) && req && resetn;
  assign sram_en    = issue;
  assign sram_wen   = issue ? wstrb : '0;
  assign sram_addr  = addr;
  assign sram_wdata = wdata;
  assign ack        = ack_q;
  assign rdata      = rdata_q;
  assign cnt_inc    = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d = '0;
          if (wstrb == '0) begin
            state_d = WAIT;
          end else begin
            state_d = DONE;
            ack_d   = 1'b1;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_inc;
        // The count reaches RD_LAT in the last wait cycle; SRAM data is valid then.
        if (cnt_inc == CW'(RD_LAT)) begin
          state_d = DONE;
          ack_d   = 1'b1;
          rdata_d = sram_rdata;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

module cpu_mem_bridge #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_req,
  input  logic [DATA_W/8-1:0] inst_wstrb,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic [DATA_W-1:0]   inst_wdata,
  output logic                inst_ack,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_sram_en,
  output logic [DATA_W/8-1:0] inst_sram_wen,
  output logic [ADDR_W-1:0]   inst_sram_addr,
  output logic [DATA_W-1:0]   inst_sram_wdata,
  input  logic [DATA_W-1:0]   inst_sram_rdata,
  input  logic                data_req,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_ack,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_sram_en,
  output logic [DATA_W/8-1:0] data_sram_wen,
  output logic [ADDR_W-1:0]   data_sram_addr,
  output logic [DATA_W-1:0]   data_sram_wdata,
  input  logic [DATA_W-1:0]   data_sram_rdata,
  output logic                stall
);
  cpu_mem_bridge_chan #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) u_inst (
    .clk(clk), .resetn(resetn), .req(inst_req), .wstrb(inst_wstrb), .addr(inst_addr),
    .wdata(inst_wdata), .ack(inst_ack), .rdata(inst_rdata), .sram_en(inst_sram_en),
    .sram_wen(inst_sram_wen), .sram_addr(inst_sram_addr), .sram_wdata(inst_sram_wdata),
    .sram_rdata(inst_sram_rdata)
  );

  cpu_mem_bridge_chan #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) u_data (
    .clk(clk), .resetn(resetn), .req(data_req), .wstrb(data_wstrb), .addr(data_addr),
    .wdata(data_wdata), .ack(data_ack), .rdata(data_rdata), .sram_en(data_sram_en),
    .sram_wen(data_sram_wen), .sram_addr(data_sram_addr), .sram_wdata(data_sram_wdata),
    .sram_rdata(data_sram_rdata)
  );

  // The ack cycle itself is not stalled: the core consumes the result there.
  assign stall = (inst_req & ~inst_ack) | (data_req & ~data_ack);
endmodule
